gol_gen_sequencer: RTL and testbench



---
 rtl/gol_gen_if.sv | 33 +++
 rtl/gol_gen_sequencer.sv | 156 +++++++++++++++
 tb/tb_gol_gen_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gol_gen_if.sv
// Request and strobe bundle between the Game-of-Life generation sequencer and its pacing/datapath peers.
// master drives pacing requests and consumes strobes; slave is the sequencer.
interface gol_gen_if #(
    parameter int unsigned BIT_WIDTH  = 3,
    parameter int unsigned BIT_HEIGHT = 3,
    parameter int unsigned PERIOD_W   = 4
);
    localparam int unsigned IDX_W = BIT_WIDTH + BIT_HEIGHT;

    logic                frame_tick;
    logic                run;
    logic                step;
    logic                reseed;
    logic [PERIOD_W-1:0] period;
    logic [IDX_W-1:0]    cell_idx;
    logic                seed_we;
    logic                copy_we;
    logic                calc_we;
    logic                vga_source;
    logic                busy;
    logic                gen_done;
    logic [15:0]         gen_count;

    modport master (
        output frame_tick, run, step, reseed, period,
        input  cell_idx, seed_we, copy_we, calc_we, vga_source, busy, gen_done, gen_count
    );

    modport slave (
        input  frame_tick, run, step, reseed, period,
        output cell_idx, seed_we, copy_we, calc_we, vga_source, busy, gen_done, gen_count
    );
endinterface

// File: rtl/gol_gen_sequencer.sv
// Game-of-Life generation sequencer: walks the cell index through SEED, COPY and CALC passes,
// drives the datapath write strobes and VGA buffer select, and paces generations from frame ticks.
module gol_gen_sequencer #(
    parameter int unsigned BIT_WIDTH  = 3,
    parameter int unsigned BIT_HEIGHT = 3,
    parameter int unsigned PERIOD_W   = 4
) (
    input logic      clk,
    input logic      reset,
    gol_gen_if.slave bus
);
    localparam int unsigned IDX_W = BIT_WIDTH + BIT_HEIGHT;
    localparam int unsigned SIZE  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic [2:0] {IDLE, SEED, COPY, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                seed_we_q, seed_we_d;
    logic                copy_we_q, copy_we_d;
    logic                calc_we_q, calc_we_d;
    logic                vga_q, vga_d;
    logic                busy_q, busy_d;
    logic                gen_done_q, gen_done_d;
    logic [15:0]         gen_count_q, gen_count_d;
    logic                seed_pend_q, seed_pend_d;
    logic                gen_pend_q, gen_pend_d;
    logic                tick_pend_q, tick_pend_d;
    logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [PERIOD_W-1:0] period_m1;
    logic                tick_hit;
    logic                last_idx;

    // Frame pacing; >= lets a shortened period fire on the very next tick.
    always_comb begin
        period_m1   = (bus.period == '0) ? '0 : bus.period - PERIOD_W'(1);
        tick_hit    = bus.run & bus.frame_tick & (frame_cnt_q >= period_m1);
        frame_cnt_d = frame_cnt_q;
        if (!bus.run) begin
            frame_cnt_d = '0;
        end else if (bus.frame_tick) begin
            frame_cnt_d = tick_hit ? '0 : frame_cnt_q + PERIOD_W'(1);
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        idx_d       = '0;
        seed_we_d   = 1'b0;
        copy_we_d   = 1'b0;
        calc_we_d   = 1'b0;
        vga_d       = 1'b0;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;
        seed_pend_d = seed_pend_q | bus.reseed;
        gen_pend_d  = gen_pend_q | bus.step;
        tick_pend_d = (tick_pend_q | tick_hit) & bus.run;
        last_idx    = (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (seed_pend_q || bus.reseed) begin
                    state_d     = SEED;
                    seed_pend_d = 1'b0;
                    seed_we_d   = 1'b1;
                end else if (gen_pend_q || tick_pend_q || bus.step || tick_hit) begin
                    state_d     = COPY;
                    gen_pend_d  = 1'b0;
                    tick_pend_d = 1'b0;
                    copy_we_d   = 1'b1;
                end
            end
            SEED: begin
                if (last_idx) begin
                    state_d     = IDLE;
                    gen_count_d = '0;
                end else begin
                    seed_we_d = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                end
            end
            COPY: begin
                if (last_idx) begin
                    state_d   = CALC;
                    calc_we_d = 1'b1;
                    vga_d     = 1'b1;
                end else begin
                    copy_we_d = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                end
            end
            CALC: begin
                if (last_idx) begin
                    state_d     = DONE;
                    gen_done_d  = 1'b1;
                    gen_count_d = gen_count_q + 16'd1;
                end else begin
                    calc_we_d = 1'b1;
                    vga_d     = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            seed_we_q   <= 1'b0;
            copy_we_q   <= 1'b0;
            calc_we_q   <= 1'b0;
            vga_q       <= 1'b0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
            seed_pend_q <= 1'b1;
            gen_pend_q  <= 1'b0;
            tick_pend_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seed_we_q   <= seed_we_d;
            copy_we_q   <= copy_we_d;
            calc_we_q   <= calc_we_d;
            vga_q       <= vga_d;
            busy_q      <= busy_d;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
            seed_pend_q <= seed_pend_d;
            gen_pend_q  <= gen_pend_d;
            tick_pend_q <= tick_pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.cell_idx   = idx_q;
    assign bus.seed_we    = seed_we_q;
    assign bus.copy_we    = copy_we_q;
    assign bus.calc_we    = calc_we_q;
    assign bus.vga_source = vga_q;
    assign bus.busy       = busy_q;
    assign bus.gen_done   = gen_done_q;
    assign bus.gen_count  = gen_count_q;
endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Directed bench for gol_gen_sequencer: seeding, single-step, frame pacing, request coalescing
// and reset mid-generation on an 8x8 board.
module tb_gol_gen_sequencer;
    localparam int unsigned BW   = 3;
    localparam int unsigned BH   = 3;
    localparam int unsigned PW   = 4;
    localparam int          SIZE = 1 << (BW + BH);

    localparam int PH_IDLE = 0;
    localparam int PH_SEED = 1;
    localparam int PH_COPY = 2;
    localparam int PH_CALC = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    gol_gen_if #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH), .PERIOD_W(PW)) bus ();

    gol_gen_sequencer #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {seed_we, copy_we, calc_we, vga_source, busy, gen_done, cell_idx} for a phase.
    function automatic logic [11:0] exp_vec(input int ph, input int idx);
        logic [5:0] i;
        i = 6'(idx);
        case (ph)
            PH_SEED: exp_vec = {6'b100010, i};
            PH_COPY: exp_vec = {6'b010010, i};
            PH_CALC: exp_vec = {6'b001110, i};
            PH_DONE: exp_vec = {6'b000011, 6'd0};
            default: exp_vec = {6'b000000, 6'd0};
        endcase
    endfunction

    function automatic logic [11:0] obs_vec();
        obs_vec = {bus.seed_we, bus.copy_we, bus.calc_we, bus.vga_source,
                   bus.busy, bus.gen_done, bus.cell_idx};
    endfunction

    task automatic chk_state(input string tag, input int ph, input int idx);
        chk(tag, 32'(obs_vec()), 32'(exp_vec(ph, idx)));
    endtask

    // Check SIZE consecutive cycles of one pass, leaving the bench on the cycle after it.
    task automatic expect_phase(input string tag, input int ph);
        for (int i = 0; i < SIZE; i++) begin
            chk_state(tag, ph, i);
            cyc();
        end
    endtask

    // Full COPY+CALC+DONE starting at the current cycle; ends observing the following IDLE cycle.
    task automatic expect_gen(input string tag, input int exp_cnt);
        expect_phase({tag, "_copy"}, PH_COPY);
        expect_phase({tag, "_calc"}, PH_CALC);
        chk_state({tag, "_done"}, PH_DONE, 0);
        chk({tag, "_count"}, 32'(bus.gen_count), 32'(exp_cnt));
        cyc();
        chk_state({tag, "_idle"}, PH_IDLE, 0);
    endtask

    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.run        = 1'b0;
        bus.step       = 1'b0;
        bus.reseed     = 1'b0;
        bus.period     = '0;
        cyc();
        cyc();
        chk_state("reset_outputs", PH_IDLE, 0);
        chk("reset_count", 32'(bus.gen_count), 32'd0);

        // Power-up seed pass follows reset release directly.
        reset = 1'b0;
        cyc();
        expect_phase("seed", PH_SEED);
        chk_state("seed_idle", PH_IDLE, 0);
        chk("seed_count", 32'(bus.gen_count), 32'd0);

        // Single step.
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        expect_gen("step1", 1);

        // Free-run at period 3: only every third tick starts a generation.
        bus.run    = 1'b1;
        bus.period = 4'd3;
        for (int k = 1; k <= 9; k++) begin
            pulse_tick();
            if (k % 3 == 0) begin
                expect_gen("p3_gen", 1 + k / 3);
            end else begin
                chk_state("p3_nogen", PH_IDLE, 0);
            end
            repeat (5) cyc();
        end

        // Period 0 behaves as 1: every tick.
        bus.period = 4'd0;
        for (int k = 1; k <= 2; k++) begin
            pulse_tick();
            expect_gen("p0_gen", 4 + k);
            repeat (3) cyc();
        end

        // Dropping run after two ticks discards the accumulated count.
        bus.period = 4'd3;
        pulse_tick();
        chk_state("drop_t1", PH_IDLE, 0);
        pulse_tick();
        chk_state("drop_t2", PH_IDLE, 0);
        bus.run = 1'b0;
        cyc();
        bus.run = 1'b1;
        pulse_tick();
        chk_state("drop_t3", PH_IDLE, 0);
        pulse_tick();
        chk_state("drop_t4", PH_IDLE, 0);
        // frame_cnt is now 2; shrinking the period to 2 makes the next tick hit.
        bus.period = 4'd2;
        pulse_tick();
        expect_gen("shrink_gen", 7);
        bus.run = 1'b0;
        repeat (3) cyc();

        // Step and reseed together: seed first, then the held generation.
        bus.step   = 1'b1;
        bus.reseed = 1'b1;
        cyc();
        bus.step   = 1'b0;
        bus.reseed = 1'b0;
        expect_phase("both_seed", PH_SEED);
        chk_state("both_gap", PH_IDLE, 0);
        chk("both_seed_count", 32'(bus.gen_count), 32'd0);
        cyc();
        expect_gen("both_gen", 1);

        // Three steps during CALC coalesce into one extra generation.
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        expect_phase("coal_copy", PH_COPY);
        for (int i = 0; i < SIZE; i++) begin
            chk_state("coal_calc", PH_CALC, i);
            bus.step = (i == 5 || i == 10 || i == 15) ? 1'b1 : 1'b0;
            cyc();
        end
        bus.step = 1'b0;
        chk_state("coal_done", PH_DONE, 0);
        chk("coal_count", 32'(bus.gen_count), 32'd2);
        cyc();
        chk_state("coal_gap", PH_IDLE, 0);
        cyc();
        expect_gen("coal_extra", 3);
        repeat (4) cyc();
        chk_state("coal_quiet", PH_IDLE, 0);

        // Reset during CALC at index 20.
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        expect_phase("rst_copy", PH_COPY);
        for (int i = 0; i < 20; i++) begin
            chk_state("rst_calc", PH_CALC, i);
            cyc();
        end
        chk_state("rst_calc20", PH_CALC, 20);
        reset = 1'b1;
        cyc();
        chk_state("rst_mid_outputs", PH_IDLE, 0);
        chk("rst_mid_count", 32'(bus.gen_count), 32'd0);
        reset = 1'b0;
        cyc();
        expect_phase("rst_seed", PH_SEED);
        chk_state("rst_idle", PH_IDLE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
